ll_display: RTL

//  Display stage for the lunar lander, downstream of ll_memory/ll_control.

---
 rtl/ll_display_if.sv | 26 ++
 rtl/ll_display.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ll_display_if.sv
// Lunar lander display bus: keysync strobe and code, telemetry from
// ll_memory/ll_control, and seven-segment, LED and selection outputs.
interface ll_display_if;
  logic        keyclk;
  logic [4:0]  keyout;
  logic [15:0] alt;
  logic [15:0] vel;
  logic [15:0] fuel;
  logic [15:0] thrust;
  logic        land;
  logic        crash;
  logic [7:0]  ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0;
  logic        red;
  logic        green;
  logic [1:0]  sel;

  modport master (
    output keyclk, keyout, alt, vel, fuel, thrust, land, crash,
    input  ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0, red, green, sel
  );

  modport slave (
    input  keyclk, keyout, alt, vel, fuel, thrust, land, crash,
    output ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0, red, green, sel
  );
endinterface

// File: rtl/ll_display.sv
// Lunar lander display stage: key-selected quantity rendered as signed 4-digit
// BCD with a mode letter, status LEDs, and digit blinking while crashed.
module ll_display #(
  parameter int unsigned BLINK_DIV = 50
) (
  input  logic       hz100,
  input  logic       rst_n,
  ll_display_if.slave io
);

  typedef enum logic [1:0] {
    SEL_ALT    = 2'd0,
    SEL_VEL    = 2'd1,
    SEL_FUEL   = 2'd2,
    SEL_THRUST = 2'd3
  } sel_e;

  localparam logic [7:0] BLINK_LAST = 8'(BLINK_DIV - 1);

  logic             keyclk_q;
  sel_e             sel_q, sel_d;
  logic [7:0]       blink_cnt_q, blink_cnt_d;
  logic             blink_on_q, blink_on_d;
  logic [7:0][7:0]  ss_q, ss_d;
  logic             red_q, green_q;

  logic             press;
  logic [15:0]      val;
  logic             neg;
  logic [15:0]      mag;
  logic             blank;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h67;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  // 9's complement of each digit, then a rippling BCD +1.
  function automatic logic [15:0] bcd_tens_comp(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    logic [4:0]  d;
    r     = '0;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, 4'd9 - v[4*i +: 4]} + {4'd0, carry};
      if (d >= 5'd10) begin
        r[4*i +: 4] = 4'(d - 5'd10);
        carry       = 1'b1;
      end else begin
        r[4*i +: 4] = d[3:0];
        carry       = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] mode_letter(input sel_e s);
    logic [7:0] l;
    case (s)
      SEL_ALT:  l = 8'h77;
      SEL_VEL:  l = 8'h3E;
      SEL_FUEL: l = 8'h71;
      default:  l = 8'h78;
    endcase
    return l;
  endfunction

  assign press = io.keyclk & ~keyclk_q;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel_d = sel_q;
    if (press) begin
      case (io.keyout)
        5'd19:   sel_d = SEL_ALT;
        5'd18:   sel_d = SEL_VEL;
        5'd17:   sel_d = SEL_FUEL;
        5'd16:   sel_d = SEL_THRUST;
        default: sel_d = sel_q;
      endcase
    end
  end

  // The mux uses the post-press selection so the new quantity appears with the letter.
  always_comb begin
    case (sel_d)
      SEL_ALT:  val = io.alt;
      SEL_VEL:  val = io.vel;
      SEL_FUEL: val = io.fuel;
      default:  val = io.thrust;
    endcase
    neg = (val[15:12] >= 4'd5);
    mag = neg ? bcd_tens_comp(val) : val;
  end

  always_comb begin
    blink_cnt_d = '0;
    blink_on_d  = 1'b1;
    if (io.crash) begin
      blink_on_d = blink_on_q;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
  end

  // Blanking follows the phase already in effect, so a fresh crash starts lit.
  assign blank = io.crash & ~blink_on_q;

  always_comb begin
    ss_d    = '0;
    ss_d[7] = mode_letter(sel_d);
    if (!blank) begin
      ss_d[4] = neg ? 8'h40 : 8'h00;
      ss_d[3] = (mag[15:12] != 4'd0) ? {1'b0, seg7(mag[15:12])} : 8'h00;
      ss_d[2] = (mag[15:8]  != 8'd0) ? {1'b0, seg7(mag[11:8])}  : 8'h00;
      ss_d[1] = (mag[15:4]  != 12'd0) ? {1'b0, seg7(mag[7:4])}  : 8'h00;
      ss_d[0] = {1'b0, seg7(mag[3:0])};
    end
  end

  // NOTE: reset is synchronous, so it is just the highest-priority branch on the clock edge.
  always_ff @(posedge hz100) begin
    if (!rst_n) begin
      keyclk_q    <= 1'b0;
      sel_q       <= SEL_ALT;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      ss_q        <= '0;
      red_q       <= 1'b0;
      green_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      keyclk_q    <= io.keyclk;
      sel_q       <= sel_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      ss_q        <= ss_d;
      red_q       <= io.crash;
      green_q     <= io.land & ~io.crash;
    end
  end

  assign io.ss7   = ss_q[7];
  assign io.ss6   = ss_q[6];
  assign io.ss5   = ss_q[5];
  assign io.ss4   = ss_q[4];
  assign io.ss3   = ss_q[3];
  assign io.ss2   = ss_q[2];
  assign io.ss1   = ss_q[1];
  assign io.ss0   = ss_q[0];
  assign io.sel   = sel_q;
  assign io.red   = red_q;
  assign io.green = green_q;

endmodule
